// File: rtl/dbi_ac_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dbi_pkg
//  Description : Shared definitions for the AC data-bus-inversion encoder:
//                default lane width, lane-word type, inversion polarity and
//                a popcount helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package dbi_pkg;

   localparam int LANE_W_DEF = 8;

   typedef logic [LANE_W_DEF-1:0] lane_word_t;

   // Level of a DBI line that marks its lane as inverted
   localparam logic DBI_INV = 1'b1;

   // Popcount over a zero-extended vector; callers cast their lane into it
   function automatic logic [6:0] popcount(input logic [63:0] v);
      logic [6:0] cnt;
      cnt = '0;
      for (int i = 0; i < 64; i++) begin
         cnt = cnt + 7'(v[i]);
      end
      return cnt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dbi_lane_decide.sv
`default_nettype none
// ============================================================================
//  Module      : dbi_lane_decide
//  Description : Combinational per-lane AC-DBI decision. Compares the cost in
//                line toggles of sending the raw lane against sending it
//                inverted, counting the data lines and the DBI line itself.
//  Ports       : raw_i      - incoming raw lane word
//                prev_i     - lane word currently driven on the bus
//                prev_dbi_i - DBI level currently driven for this lane
//                dbi_o      - DBI level chosen for the new word
//                enc_o      - encoded lane word to drive
//  Revision    : 1.0 - initial release
// ============================================================================
module dbi_lane_decide
   import dbi_pkg::*;
#(
   parameter int LANE_W = LANE_W_DEF
) (
   input  logic [LANE_W-1:0] raw_i,
   input  logic [LANE_W-1:0] prev_i,
   input  logic              prev_dbi_i,
   output logic              dbi_o,
   output logic [LANE_W-1:0] enc_o
);

   // Wide enough for LANE_W+1, the largest possible cost
   localparam int CW = $clog2(LANE_W + 2);

   logic [CW-1:0] w_k;
   logic [CW-1:0] w_t0;
   logic [CW-1:0] w_t1;

   always_comb begin
      w_k  = CW'(popcount(64'(raw_i ^ prev_i)));
      // Keeping the raw word toggles k data lines, plus the DBI line if it
      // is currently asserted. Inverting toggles the complement set of data
      // lines, plus the DBI line if it is currently deasserted.
      w_t0 = w_k + CW'(prev_dbi_i);
      w_t1 = CW'(LANE_W) - w_k + CW'(!prev_dbi_i);
      if (w_t1 < w_t0) begin
         dbi_o = DBI_INV;
      end else if (w_t0 < w_t1) begin
         dbi_o = ~DBI_INV;
      end else begin
         dbi_o = prev_dbi_i;   // tie: leave the DBI line where it is
      end
      enc_o = raw_i ^ {LANE_W{dbi_o}};
   end

endmodule
`default_nettype wire

// File: rtl/dbi_ac_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : dbi_ac_encoder
//  Description : Registered AC data-bus-inversion encoder. Each lane gets a
//                DBI line and is inverted whenever that reduces the number of
//                line toggles relative to the word last driven. Keeps a
//                saturating count of inverted lane-words.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                in_data/valid/ready - raw word input handshake
//                out_data/dbi/valid  - registered encoded word output
//                out_ready           - downstream consumes the word
//                inv_count           - saturating inverted-lane counter
//                cnt_clr             - synchronous counter clear
//  Revision    : 1.0 - initial release
// ============================================================================
module dbi_ac_encoder
   import dbi_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int LANE_W = LANE_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [LANES*LANE_W-1:0] in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [LANES*LANE_W-1:0] out_data,
   output logic [LANES-1:0]        out_dbi,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CNT_W-1:0]        inv_count,
   input  logic                    cnt_clr
);

   localparam int NW  = $clog2(LANES + 1);
   localparam int CW1 = CNT_W + 1;
   localparam logic [CNT_W:0] c_CNT_MAX = {1'b0, {CNT_W{1'b1}}};

   logic [LANES*LANE_W-1:0] data_q, data_d;
   logic [LANES-1:0]        dbi_q, dbi_d;
   logic                    valid_q, valid_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic                    w_accept;
   logic [NW-1:0]           w_lanes_inv;
   logic [CNT_W:0]          w_cnt_sum;

   assign in_ready = !valid_q || out_ready;
   assign w_accept = in_valid && in_ready;

   // Decisions are always referenced to the registered bus, which keeps its
   // level through idle cycles.
   generate
      for (genvar n = 0; n < LANES; n++) begin : g_lane
         dbi_lane_decide #(
            .LANE_W     (LANE_W)
         ) u_decide (
            .raw_i      (in_data[n*LANE_W +: LANE_W]),
            .prev_i     (data_q[n*LANE_W +: LANE_W]),
            .prev_dbi_i (dbi_q[n]),
            .dbi_o      (dbi_d[n]),
            .enc_o      (data_d[n*LANE_W +: LANE_W])
         );
      end
   endgenerate

   always_comb begin
      w_lanes_inv = '0;
      for (int n = 0; n < LANES; n++) begin
         w_lanes_inv = w_lanes_inv + NW'(dbi_d[n] == DBI_INV);
      end
      // One extra bit so the overflow is visible before clamping
      w_cnt_sum = {1'b0, cnt_q} + CW1'(w_lanes_inv);

      valid_d = valid_q;
      if (w_accept) begin
         valid_d = 1'b1;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end

      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (w_accept) begin
         cnt_d = (w_cnt_sum > c_CNT_MAX) ? c_CNT_MAX[CNT_W-1:0]
                                         : w_cnt_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         dbi_q   <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         if (w_accept) begin
            data_q <= data_d;
            dbi_q  <= dbi_d;
         end
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_data  = data_q;
   assign out_dbi   = dbi_q;
   assign out_valid = valid_q;
   assign inv_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dbi_ac_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dbi_ac_encoder
//  Description : Self-checking bench for dbi_ac_encoder with a toggle-count
//                reference model of the bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dbi_ac_encoder;

   localparam int LANES  = 4;
   localparam int LANE_W = 8;
   localparam int CNT_W  = 16;
   localparam int c_MAX  = (1 << CNT_W) - 1;

   logic        clk;
   logic        rst_n;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic [3:0]  out_dbi;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] inv_count;
   logic        cnt_clr;

   int n_run;
   int n_fail;

   // Reference model of the bus state
   logic [31:0] m_data;
   logic [3:0]  m_dbi;
   logic        m_valid;
   int          m_cnt;

   dbi_ac_encoder #(
      .LANES     (LANES),
      .LANE_W    (LANE_W),
      .CNT_W     (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_dbi   (out_dbi),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .inv_count (inv_count),
      .cnt_clr   (cnt_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, advance one edge and update the model by
   // counting the actual line toggles each encoding would cause.
   task automatic step(input logic [31:0] d, input logic v, input logic r,
                       input logic c);
      logic        acc;
      logic [31:0] nd;
      logic [3:0]  nb;
      int          ninv;
      in_data = d; in_valid = v; out_ready = r; cnt_clr = c;
      @(posedge clk);
      acc  = v && (!m_valid || r);
      nd   = m_data;
      nb   = m_dbi;
      ninv = 0;
      for (int n = 0; n < LANES; n++) begin
         logic [7:0] raw, p;
         int cost_plain, cost_inv;
         raw = d[n*8 +: 8];
         p   = m_data[n*8 +: 8];
         cost_plain = $countones(raw ^ p)  + ((m_dbi[n] != 1'b0) ? 1 : 0);
         cost_inv   = $countones(~raw ^ p) + ((m_dbi[n] != 1'b1) ? 1 : 0);
         if (cost_inv < cost_plain)      nb[n] = 1'b1;
         else if (cost_plain < cost_inv) nb[n] = 1'b0;
         nd[n*8 +: 8] = nb[n] ? ~raw : raw;
         if (nb[n]) ninv++;
      end
      if (c) m_cnt = 0;
      else if (acc) m_cnt = (m_cnt + ninv > c_MAX) ? c_MAX : m_cnt + ninv;
      if (acc) begin
         m_data  = nd;
         m_dbi   = nb;
         m_valid = 1'b1;
      end else if (r) begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      cnt_clr = 1'b0;
      m_data = '0; m_dbi = '0; m_valid = 1'b0; m_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_run++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      do_reset();
      n_run++;
      if ({out_valid, out_dbi, out_data, inv_count} !== 53'd0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b dbi=%h data=%h cnt=%0d expected all zero",
                  out_valid, out_dbi, out_data, inv_count);
      end
   endtask

   task automatic test_first_word();
      do_reset();
      step(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
      n_run++;
      if (out_valid !== 1'b1 || out_data !== 32'h0 || out_dbi !== 4'hF ||
          inv_count !== 16'd4) begin
         n_fail++;
         $display("FAIL first_word: got v=%b data=%h dbi=%h cnt=%0d expected v=1 data=00000000 dbi=f cnt=4",
                  out_valid, out_data, out_dbi, inv_count);
      end
   endtask

   task automatic test_k4();
      do_reset();
      step(32'h0F0F_0F0F, 1'b1, 1'b1, 1'b0);
      n_run++;
      if (out_data !== 32'h0F0F_0F0F || out_dbi !== 4'h0) begin
         n_fail++;
         $display("FAIL k4_dbi0: got data=%h dbi=%h expected 0f0f0f0f/0", out_data, out_dbi);
      end
      do_reset();
      step(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
      step(32'h0F0F_0F0F, 1'b1, 1'b1, 1'b0);
      n_run++;
      if (out_data !== 32'hF0F0_F0F0 || out_dbi !== 4'hF || inv_count !== 16'd8) begin
         n_fail++;
         $display("FAIL k4_dbi1: got data=%h dbi=%h cnt=%0d expected f0f0f0f0/f/8",
                  out_data, out_dbi, inv_count);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] hold_d;
      logic [3:0]  hold_b;
      int          delivered;
      logic [31:0] sent[$];
      do_reset();
      step(32'h1234_5678, 1'b1, 1'b1, 1'b0);
      hold_d = out_data; hold_b = out_dbi;
      for (int i = 0; i < 3; i++) begin
         step(32'hA5A5_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
         n_run++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== hold_d ||
             out_dbi !== hold_b) begin
            n_fail++;
            $display("FAIL backpressure_hold: got rdy=%b v=%b data=%h dbi=%h expected rdy=0 v=1 data=%h dbi=%h",
                     in_ready, out_valid, out_data, out_dbi, hold_d, hold_b);
         end
      end
      // Single-cycle ready pulses: each must hand over exactly one new word
      delivered = 0;
      for (int i = 0; i < 4; i++) begin
         sent.push_back(m_data);
         step(32'hC3C3_0000 + 32'(i), 1'b1, 1'b1, 1'b0);
         delivered++;
         n_run++;
         if (out_valid !== 1'b1 || out_data !== m_data || out_dbi !== m_dbi) begin
            n_fail++;
            $display("FAIL backpressure_pulse: got v=%b data=%h dbi=%h expected v=1 data=%h dbi=%h",
                     out_valid, out_data, out_dbi, m_data, m_dbi);
         end
         step(32'hDEAD_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
      end
      n_run++;
      if (inv_count !== 16'(m_cnt) || delivered != sent.size()) begin
         n_fail++;
         $display("FAIL backpressure_count: got cnt=%0d expected %0d", inv_count, m_cnt);
      end
   endtask

   task automatic test_idle_gap();
      do_reset();
      step(32'h0F0F_0F0F, 1'b1, 1'b1, 1'b0);
      repeat (5) step(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
      n_run++;
      if (out_valid !== 1'b0 || out_data !== 32'h0F0F_0F0F) begin
         n_fail++;
         $display("FAIL idle_hold: got v=%b data=%h expected v=0 data=0f0f0f0f",
                  out_valid, out_data);
      end
      // 0x1F differs from the held 0x0F in one bit, from 0x00 in five;
      // send 0x10 per lane, which is five bits away from the held bus.
      step(32'h1010_1010, 1'b1, 1'b1, 1'b0);
      n_run++;
      if (out_dbi !== 4'hF || out_data !== 32'hEFEF_EFEF) begin
         n_fail++;
         $display("FAIL idle_reference: got data=%h dbi=%h expected efefefef/f",
                  out_data, out_dbi);
      end
   endtask

   task automatic test_random();
      logic [52:0] got, exp;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         step($urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 40) == 0));
         got = {out_valid, out_dbi, out_data, inv_count};
         exp = {m_valid, m_dbi, m_data, 16'(m_cnt)};
         n_run++;
         if (got !== exp || in_ready !== (!m_valid || out_ready)) begin
            n_fail++;
            $display("FAIL random_cycle%0d: got %h rdy=%b expected %h rdy=%b",
                     i, got, in_ready, exp, (!m_valid || out_ready));
         end
      end
   endtask

   task automatic test_counter();
      do_reset();
      for (int i = 0; i < 16383; i++) step(~m_data, 1'b1, 1'b1, 1'b0);
      // Two lanes re-inverted, two left plain
      step({m_data[31:16], ~m_data[15:0]}, 1'b1, 1'b1, 1'b0);
      n_run++;
      if (inv_count !== 16'(c_MAX - 1) || inv_count !== 16'(m_cnt)) begin
         n_fail++;
         $display("FAIL counter_preload: got %0d expected %0d", inv_count, c_MAX - 1);
      end
      step(~m_data, 1'b1, 1'b1, 1'b0);
      n_run++;
      if (inv_count !== 16'(c_MAX) || out_dbi !== 4'hF) begin
         n_fail++;
         $display("FAIL counter_saturate: got cnt=%0d dbi=%h expected %0d/f",
                  inv_count, out_dbi, c_MAX);
      end
      step(~m_data, 1'b1, 1'b1, 1'b0);
      n_run++;
      if (inv_count !== 16'(c_MAX)) begin
         n_fail++;
         $display("FAIL counter_stay_sat: got %0d expected %0d", inv_count, c_MAX);
      end
      step(~m_data, 1'b1, 1'b1, 1'b1);
      n_run++;
      if (inv_count !== 16'd0 || out_valid !== 1'b1 || out_dbi !== m_dbi) begin
         n_fail++;
         $display("FAIL counter_clear: got cnt=%0d v=%b dbi=%h expected 0/1/%h",
                  inv_count, out_valid, out_dbi, m_dbi);
      end
   endtask

   task automatic test_mid_reset();
      step(32'h8E3C_71A5, 1'b1, 1'b1, 1'b0);
      step(32'h5555_AAAA, 1'b1, 1'b0, 1'b0);
      n_run++;
      if (out_valid !== 1'b1 || out_data !== m_data) begin
         n_fail++;
         $display("FAIL mid_reset_pre: got v=%b data=%h expected v=1 data=%h",
                  out_valid, out_data, m_data);
      end
      #2 rst_n = 1'b0;
      #1;
      n_run++;
      if ({out_valid, out_dbi, out_data, inv_count} !== 53'd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset_async: got v=%b dbi=%h data=%h cnt=%0d rdy=%b expected zeros rdy=1",
                  out_valid, out_dbi, out_data, inv_count, in_ready);
      end
      do_reset();
      step(32'h1F1F_1F1F, 1'b1, 1'b1, 1'b0);
      n_run++;
      if (out_data !== 32'hE0E0_E0E0 || out_dbi !== 4'hF || inv_count !== 16'd4) begin
         n_fail++;
         $display("FAIL mid_reset_after: got data=%h dbi=%h cnt=%0d expected e0e0e0e0/f/4",
                  out_data, out_dbi, inv_count);
      end
   endtask

   initial begin
      n_run = 0;
      n_fail = 0;
      rst_n = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
      m_data = '0; m_dbi = '0; m_valid = 1'b0; m_cnt = 0;
      #2;
      test_reset();
      test_first_word();
      test_k4();
      test_backpressure();
      test_idle_gap();
      test_random();
      test_counter();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dbi_ac_encoder.md
Name: dbi_ac_encoder

Overview:
- Registered AC (transition-minimising) Data Bus Inversion encoder for the transmit side of the bus.
- Each LANE_W-bit lane carries one DBI line. Per lane, the block compares the incoming word against the last word driven on the lane's data lines and DBI line, and inverts the word when that gives fewer line toggles.
- Sits between the valid/ready data source and the pad/serializer stage.
- Also keeps a saturating count of inverted lane-words for link statistics.

Parameters:
- LANES, 4, number of byte lanes, each with its own DBI line.
- LANE_W, 8, data bits per lane.
- CNT_W, 16, width of the inversion statistics counter.

Ports:
- clk  input  1  single clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous assert, active-low reset.
- in_data  input  LANES*LANE_W  raw word; lane n is bits [n*LANE_W +: LANE_W].
- in_valid  input  1  in_data is valid.
- in_ready  output  1  encoder can accept a word this cycle.
- out_data  output  LANES*LANE_W  encoded bus word; equals the raw word XOR {LANE_W{out_dbi[n]}} per lane.
- out_dbi  output  LANES  per-lane DBI flag; 1 means the lane is inverted.
- out_valid  output  1  out_data and out_dbi hold a new word.
- out_ready  input  1  downstream consumes the word.
- inv_count  output  CNT_W  saturating count of inverted lane-words.
- cnt_clr  input  1  synchronous clear of inv_count.

Behaviour:
- Reset (async, rst_n=0):
  - out_data=0, out_dbi=0, out_valid=0, inv_count=0.
  - in_ready follows its equation, so it is 1 while in reset.
  - Reset asserted mid-transfer drops any pending word. No partial update is allowed.
- Handshake and latency:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept happens when in_valid && in_ready. The encoded word appears on the next edge with out_valid=1, so latency is 1 cycle. Full throughput is 1 word/cycle.
  - With out_valid=1 and out_ready=0, all outputs hold stable and no word is accepted.
  - Without an accept, out_valid clears once out_ready is seen. out_data and out_dbi keep their last values (the bus keeps its level) and stay the transition reference.
- Decision, per lane n, evaluated on accept:
  - P = current out_data lane, D = current out_dbi[n], k = popcount(in lane XOR P).
  - Cost without inversion: t0 = k + D.
  - Cost with inversion: t1 = (LANE_W - k) + (1 - D).
  - Set new dbi = 1 if t1 < t0. Set new dbi = 0 if t0 < t1. On a tie, new dbi = D.
  - With LANE_W=8: when D=0, invert iff k>=5; when D=1, invert iff k>=4. Ties cannot occur for even LANE_W.
  - Lanes are independent of each other.
- Register update on accept: out_data lane = in lane XOR {LANE_W{new dbi}}; out_dbi[n] = new dbi.
- Counter:
  - On accept, inv_count += number of lanes with new dbi=1, saturating at 2^CNT_W-1.
  - cnt_clr has priority: inv_count=0 that cycle, and the increment in the same cycle is discarded.
- Widths: k and the costs are sized to clog2(LANE_W+2) bits. The lane-count adder is sized to clog2(LANES+1) bits. Saturation is compared in the CNT_W+1-bit domain.

Decomposition:
- Shared package dbi_pkg:
  - LANE_W_DEF=8 and a lane-word typedef.
  - Popcount function.
  - DBI polarity constant DBI_INV=1'b1.
- One sub-module, dbi_lane_decide: combinational. Inputs are the raw lane, the previous lane and the previous dbi. Outputs are the new dbi and the encoded lane. It is instantiated LANES times in a generate loop.
- The top level holds the output registers, the handshake and the counter.

Test Plan:
- Reset release, then accept in_data=32'hFFFF_FFFF (LANES=4) -> out_data=0, out_dbi=4'hF, inv_count=4, latency 1 cycle.
- From bus 0 / dbi 0: lane 8'h0F (k=4) -> dbi=0, lane out 8'h0F. From dbi 1 with P=8'h00: lane 8'h0F (k=4) -> dbi=1, out 8'hF0.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, outputs stable, exactly one word delivered per out_ready pulse, no word lost or duplicated.
- Idle gap of 5 cycles, then a word differing in 5 bits from the held bus -> inverted. The decision uses the held bus, not zero.
- Counter: preload to 2^CNT_W-2, accept 4 inverted lanes -> inv_count saturates at 2^CNT_W-1. cnt_clr with a simultaneous accept -> inv_count=0.
- Assert rst_n low mid-stream with out_valid=1 -> outputs immediately 0, out_valid=0. Post-reset decisions are referenced to an all-zero bus with dbi 0.
